macro_run_sequencer: RTL

MACRO_RUN_SEQUENCER -- requirements
Module: macro_run_sequencer

---
 rtl/lagd_seq_pkg.sv | 40 ++++
 rtl/seq_watchdog.sv | 31 +++
 rtl/macro_run_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/lagd_seq_pkg.sv
// Shared types and default widths for the macro run sequencer.
// The optional watchdog is enabled by defining MACRO_RUN_SEQUENCER_TIMEOUT_EN.
package lagd_seq_pkg;

    localparam int DEFAULT_COUNTER_BITWIDTH = 16;
    localparam int DEFAULT_TIMEOUT_BIT      = 20;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CFG,
        S_LOAD,
        S_LOAD_WAIT,
        S_RUN,
        S_RUN_WAIT,
        S_READ,
        S_DONE,
        S_ERR
    } seq_state_e;

    // Everything the sequencer drives out, registered as one bundle.
    typedef struct packed {
        logic en;
        logic cfg_valid;
        logic flush;
        logic dt_cfg_enable;
        logic cmpt_en;
        logic host_readout;
        logic done;
        logic busy;
    } seq_out_t;

    function automatic logic is_active(input seq_state_e s);
        return (s != S_IDLE) && (s != S_ERR);
    endfunction

    function automatic logic is_wait(input seq_state_e s);
        return (s == S_LOAD_WAIT) || (s == S_RUN_WAIT);
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Cycle watchdog for the sequencer's wait states; only instantiated when
// MACRO_RUN_SEQUENCER_TIMEOUT_EN is defined. A limit of 0 never expires.
module seq_watchdog
    import lagd_seq_pkg::*;
#(
    parameter int TIMEOUT_BIT = DEFAULT_TIMEOUT_BIT
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   active_i,
    input  logic                   restart_i,
    input  logic [TIMEOUT_BIT-1:0] limit_i,
    output logic                   expired_o
);

    logic [TIMEOUT_BIT-1:0] cnt_q;
    logic [TIMEOUT_BIT-1:0] elapsed;

    // Cycles spent in the current wait state, including this one.
    assign elapsed   = restart_i ? TIMEOUT_BIT'(1) : cnt_q + 1'b1;
    assign expired_o = active_i && (limit_i != '0) && (elapsed == limit_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= active_i ? elapsed : '0;
        end
    end

endmodule

// File: rtl/macro_run_sequencer.sv
// Sequences config, weight load, N compute runs and readout for one macro.
// Define MACRO_RUN_SEQUENCER_TIMEOUT_EN to add the wait-state watchdog and ERR path.
module macro_run_sequencer
    import lagd_seq_pkg::*;
#(
    parameter int COUNTER_BITWIDTH = DEFAULT_COUNTER_BITWIDTH,
    parameter int TIMEOUT_BIT      = DEFAULT_TIMEOUT_BIT
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic                        abort_i,
    input  logic                        skip_load_i,
    input  logic [COUNTER_BITWIDTH-1:0] num_runs_i,
    input  logic [TIMEOUT_BIT-1:0]      timeout_cycles_i,
    output logic                        en_aw_o,
    output logic                        en_em_o,
    output logic                        en_fm_o,
    output logic                        config_valid_em_o,
    output logic                        config_valid_fm_o,
    output logic                        config_valid_aw_o,
    output logic                        flush_o,
    output logic                        dt_cfg_enable_o,
    input  logic                        dt_cfg_idle_i,
    output logic                        cmpt_en_o,
    input  logic                        cmpt_idle_i,
    output logic                        host_readout_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        error_o,
    output logic [COUNTER_BITWIDTH-1:0] run_count_o
);

    seq_state_e                  state_q, state_d;
    logic                        first_q;
    logic [COUNTER_BITWIDTH-1:0] num_runs_q;
    logic                        skip_load_q;
    logic [COUNTER_BITWIDTH-1:0] run_count_q;
    logic [COUNTER_BITWIDTH-1:0] run_count_inc;
    logic                        accept;
    logic                        run_done;
    logic                        timeout_hit;
    seq_out_t                    out_d, out_q;

    assign accept        = (state_q == S_IDLE) && start_i && !abort_i;
    assign run_count_inc = run_count_q + 1'b1;
    assign run_done      = (state_q == S_RUN_WAIT) &&
                           ((state_d == S_READ) || (state_d == S_RUN));

    // NOTE: state and data registers use non-blocking assignment so every
    // flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= (state_d != state_q);
        end
    end

    // NOTE: state_d gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (accept) state_d = (num_runs_i == '0) ? S_DONE : S_CFG;
            S_CFG:       state_d = skip_load_q ? S_RUN : S_LOAD;
            S_LOAD:      state_d = S_LOAD_WAIT;
            S_LOAD_WAIT: begin
                if (timeout_hit)                   state_d = S_ERR;
                else if (!first_q && dt_cfg_idle_i) state_d = S_RUN;
            end
            S_RUN:       state_d = S_RUN_WAIT;
            S_RUN_WAIT: begin
                if (timeout_hit)                  state_d = S_ERR;
                else if (!first_q && cmpt_idle_i)
                    state_d = (run_count_inc == num_runs_q) ? S_READ : S_RUN;
            end
            S_READ:      state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            S_ERR:       state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
        if (abort_i && (state_q != S_IDLE)) state_d = S_IDLE;
    end

    // Outputs decode the upcoming state so they are registered yet aligned with it.
    always_comb begin
        out_d      = '0;
        out_d.en   = is_active(state_d);
        out_d.busy = is_active(state_d);
        unique case (state_d)
            S_CFG: begin
                out_d.cfg_valid = 1'b1;
                out_d.flush     = 1'b1;
            end
            S_LOAD:  out_d.dt_cfg_enable = 1'b1;
            S_RUN:   out_d.cmpt_en       = 1'b1;
            S_READ:  out_d.host_readout  = 1'b1;
            S_DONE:  out_d.done          = 1'b1;
            S_ERR:   out_d.flush         = 1'b1;
            default: ;
        endcase
        if (abort_i && ((state_q != S_IDLE) || start_i)) out_d.flush = 1'b1;
    end

    // NOTE: every register here is a control flop, so all take the async reset;
    // nothing is a memory array that could skip it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q       <= '0;
            num_runs_q  <= '0;
            skip_load_q <= 1'b0;
            run_count_q <= '0;
        end else begin
            out_q <= out_d;
            if (accept) begin
                num_runs_q  <= num_runs_i;
                skip_load_q <= skip_load_i;
                run_count_q <= '0;
            end else if (run_done) begin
                run_count_q <= run_count_inc;
            end
        end
    end

`ifdef MACRO_RUN_SEQUENCER_TIMEOUT_EN
    logic error_q;

    seq_watchdog #(
        .TIMEOUT_BIT (TIMEOUT_BIT)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .active_i  (is_wait(state_q)),
        .restart_i (first_q),
        .limit_i   (timeout_cycles_i),
        .expired_o (timeout_hit)
    );

    // Sticky until the next accepted start.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            error_q <= 1'b0;
        end else if (accept) begin
            error_q <= 1'b0;
        end else if (state_d == S_ERR) begin
            error_q <= 1'b1;
        end
    end

    assign error_o = error_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^timeout_cycles_i;
    assign timeout_hit    = 1'b0;
    assign error_o        = 1'b0;
`endif

    assign en_aw_o           = out_q.en;
    assign en_em_o           = out_q.en;
    assign en_fm_o           = out_q.en;
    assign config_valid_em_o = out_q.cfg_valid;
    assign config_valid_fm_o = out_q.cfg_valid;
    assign config_valid_aw_o = out_q.cfg_valid;
    assign flush_o           = out_q.flush;
    assign dt_cfg_enable_o   = out_q.dt_cfg_enable;
    assign cmpt_en_o         = out_q.cmpt_en;
    assign host_readout_o    = out_q.host_readout;
    assign busy_o            = out_q.busy;
    assign done_o            = out_q.done;
    assign run_count_o       = run_count_q;

endmodule
